// File: rtl/decode_execute_core.sv
// Two-stage MIPS decode/execute: stage 1 reads registers and latches decoded fields, stage 2 registers results.
// Latency 2 cycles, one instruction per cycle, never stalls; a same-cycle write-back is bypassed to the reads.
module decode_execute_core #(
  parameter logic [31:0] SP_RESET = 32'h8002_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] insn,
  input  logic [31:0] pc_in,
  input  logic        valid_insn,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] data_out,
  output logic        out_valid,
  output logic [4:0]  dest_reg,
  output logic [31:0] rt_data_out,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
                         OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f,
                         OP_LB = 6'h20, OP_LW = 6'h23, OP_LBU = 6'h24, OP_SB = 6'h28, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                         F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2a, F_SLTU = 6'h2b;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } s1_t;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target26;

  assign opcode   = insn[31:26];
  assign rs       = insn[25:21];
  assign rt       = insn[20:16];
  assign rd       = insn[15:11];
  assign shamt    = insn[10:6];
  assign funct    = insn[5:0];
  assign imm16    = insn[15:0];
  assign target26 = insn[25:0];

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic        wb_hit;
  logic [31:0] rs_rd, rt_rd;

  always_comb begin
    wb_hit = wb_en && (wb_addr != 5'd0);
    rf_d = rf_q;
    if (wb_hit) rf_d[wb_addr] = wb_data;
    rs_rd = rf_q[rs];
    rt_rd = rf_q[rt];
    if (rs == 5'd0) rs_rd = 32'd0;
    else if (wb_hit && wb_addr == rs) rs_rd = wb_data;
    if (rt == 5'd0) rt_rd = 32'd0;
    else if (wb_hit && wb_addr == rt) rt_rd = wb_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= (i == 29) ? SP_RESET : 32'd0;
    end else begin
      rf_q <= rf_d;
    end
  end

  s1_t  s1_q, s1_d;
  logic s1_vld_q, s1_vld_d;

  always_comb begin
    s1_vld_d = valid_insn;
    s1_d     = s1_q;
    if (valid_insn) begin
      s1_d = '{op: opcode, rt: rt, rd: rd, shamt: shamt, funct: funct, imm: imm16,
               tgt: target26, pc: pc_in, rs_val: rs_rd, rt_val: rt_rd};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
    end
  end

  logic [31:0] rs_v, rt_v, sext, zext, pc4, pc8, br_tgt, res, tgt;
  logic [4:0]  dst;
  logic        take;
  logic [31:0] data_out_q, data_out_d, rt_data_out_q, rt_data_out_d, branch_target_q, branch_target_d;
  logic [4:0]  dest_reg_q, dest_reg_d;
  logic        out_valid_q, out_valid_d, branch_taken_q, branch_taken_d;

  always_comb begin
    rs_v   = s1_q.rs_val;
    rt_v   = s1_q.rt_val;
    sext   = {{16{s1_q.imm[15]}}, s1_q.imm};
    zext   = {16'd0, s1_q.imm};
    pc4    = s1_q.pc + 32'd4;
    pc8    = s1_q.pc + 32'd8;
    br_tgt = pc4 + {sext[29:0], 2'b00};
    res    = 32'd0;
    dst    = 5'd0;
    take   = 1'b0;
    tgt    = 32'd0;
    case (s1_q.op)
      OP_RTYPE: begin
        dst = s1_q.rd;
        case (s1_q.funct)
          F_SLL:         res = rt_v << s1_q.shamt;
          F_SRL:         res = rt_v >> s1_q.shamt;
          F_SRA:         res = $unsigned($signed(rt_v) >>> s1_q.shamt);
          F_SLLV:        res = rt_v << rs_v[4:0];
          F_SRLV:        res = rt_v >> rs_v[4:0];
          F_SRAV:        res = $unsigned($signed(rt_v) >>> rs_v[4:0]);
          F_JR:          begin dst = 5'd0; take = 1'b1; tgt = rs_v; end
          F_JALR:        begin res = pc8; take = 1'b1; tgt = rs_v; end
          F_ADD, F_ADDU: res = rs_v + rt_v;
          F_SUB, F_SUBU: res = rs_v - rt_v;
          F_AND:         res = rs_v & rt_v;
          F_OR:          res = rs_v | rt_v;
          F_XOR:         res = rs_v ^ rt_v;
          F_NOR:         res = ~(rs_v | rt_v);
          F_SLT:         res = {31'd0, $signed(rs_v) < $signed(rt_v)};
          F_SLTU:        res = {31'd0, rs_v < rt_v};
          default:       dst = 5'd0;
        endcase
      end
      // rt selects BLTZ (0) or BGEZ (1); other REGIMM encodings never redirect
      OP_REGIMM: begin
        tgt = br_tgt;
        if (s1_q.rt == 5'd0)      take = rs_v[31];
        else if (s1_q.rt == 5'd1) take = !rs_v[31];
      end
      OP_J:                begin take = 1'b1; tgt = {pc4[31:28], s1_q.tgt, 2'b00}; end
      OP_JAL:              begin take = 1'b1; tgt = {pc4[31:28], s1_q.tgt, 2'b00}; res = pc8; dst = 5'd31; end
      OP_BEQ:              begin tgt = br_tgt; take = (rs_v == rt_v); end
      OP_BNE:              begin tgt = br_tgt; take = (rs_v != rt_v); end
      OP_BLEZ:             begin tgt = br_tgt; take = rs_v[31] || (rs_v == 32'd0); end
      OP_BGTZ:             begin tgt = br_tgt; take = !rs_v[31] && (rs_v != 32'd0); end
      OP_ADDI, OP_ADDIU:   begin res = rs_v + sext; dst = s1_q.rt; end
      OP_SLTI:             begin res = {31'd0, $signed(rs_v) < $signed(sext)}; dst = s1_q.rt; end
      OP_SLTIU:            begin res = {31'd0, rs_v < sext}; dst = s1_q.rt; end
      OP_ANDI:             begin res = rs_v & zext; dst = s1_q.rt; end
      OP_ORI:              begin res = rs_v | zext; dst = s1_q.rt; end
      OP_XORI:             begin res = rs_v ^ zext; dst = s1_q.rt; end
      OP_LUI:              begin res = {s1_q.imm, 16'd0}; dst = s1_q.rt; end
      OP_LB, OP_LW, OP_LBU: begin res = rs_v + sext; dst = s1_q.rt; end
      OP_SB, OP_SW:        res = rs_v + sext;
      default:             ;
    endcase

    // Bubbles hold the data outputs; only valid, redirect and destination drop to zero
    out_valid_d     = s1_vld_q;
    branch_taken_d  = s1_vld_q & take;
    dest_reg_d      = s1_vld_q ? dst : 5'd0;
    data_out_d      = s1_vld_q ? res : data_out_q;
    rt_data_out_d   = s1_vld_q ? rt_v : rt_data_out_q;
    branch_target_d = s1_vld_q ? tgt : branch_target_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q     <= 1'b0;
      branch_taken_q  <= 1'b0;
      dest_reg_q      <= 5'd0;
      data_out_q      <= 32'd0;
      rt_data_out_q   <= 32'd0;
      branch_target_q <= 32'd0;
    end else begin
      out_valid_q     <= out_valid_d;
      branch_taken_q  <= branch_taken_d;
      dest_reg_q      <= dest_reg_d;
      data_out_q      <= data_out_d;
      rt_data_out_q   <= rt_data_out_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign branch_taken  = branch_taken_q;
  assign dest_reg      = dest_reg_q;
  assign data_out      = data_out_q;
  assign rt_data_out   = rt_data_out_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_decode_execute_core.sv
// Directed bench for decode_execute_core: hand-computed vectors per feature, one task per scenario.
module tb_decode_execute_core;

  localparam logic [31:0] SP_RST = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] insn = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic        valid_insn = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [31:0] data_out, rt_data_out, branch_target;
  logic        out_valid, branch_taken;
  logic [4:0]  dest_reg;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] t_ins [16];
  logic [4:0]  t_dst [16];
  logic [31:0] t_dat [16];

  decode_execute_core #(.SP_RESET(SP_RST)) dut (
    .clock(clock), .reset(reset), .insn(insn), .pc_in(pc_in), .valid_insn(valid_insn),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .data_out(data_out),
    .out_valid(out_valid), .dest_reg(dest_reg), .rt_data_out(rt_data_out),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // Issue one instruction; returns at the falling edge where its result is visible
  task automatic exec(input logic [31:0] i, input logic [31:0] p);
    @(negedge clock); insn = i; pc_in = p; valid_insn = 1'b1;
    @(negedge clock); valid_insn = 1'b0;
    @(negedge clock);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock); wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clock); wb_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; valid_insn = 1'b1;
    insn = enc_i(6'h09, 5'd0, 5'd8, 16'd5);
    repeat (2) @(negedge clock);
    reset = 1'b0; wb_en = 1'b0; valid_insn = 1'b0;
    tests_run++;
    if ({out_valid, branch_taken, dest_reg} !== 7'd0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %h exp 0", {out_valid, branch_taken, dest_reg});
    end
    tests_run++;
    if ({data_out, rt_data_out, branch_target} !== 96'd0) begin
      tests_failed++; $display("FAIL reset_data: got %h exp 0", {data_out, rt_data_out, branch_target});
    end
    repeat (2) @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_insn_dropped: out_valid got %b exp 0", out_valid);
    end
    exec(enc_r(5'd29, 5'd0, 5'd1, 5'd0, 6'h21), 32'd0);
    tests_run++;
    if ({out_valid, dest_reg, data_out} !== {1'b1, 5'd1, SP_RST}) begin
      tests_failed++; $display("FAIL reset_sp: got %h exp %h", {out_valid, dest_reg, data_out}, {1'b1, 5'd1, SP_RST});
    end
    exec(enc_r(5'd5, 5'd0, 5'd2, 5'd0, 6'h21), 32'd0);
    tests_run++;
    if ({out_valid, dest_reg, data_out} !== {1'b1, 5'd2, 32'd0}) begin
      tests_failed++; $display("FAIL reset_blocks_wb: got %h exp %h", {out_valid, dest_reg, data_out}, {1'b1, 5'd2, 32'd0});
    end
  endtask

  task automatic test_addiu();
    exec(enc_i(6'h09, 5'd0, 5'd8, 16'd5), 32'd0);
    tests_run++;
    if ({out_valid, branch_taken, dest_reg, data_out} !== {1'b1, 1'b0, 5'd8, 32'd5}) begin
      tests_failed++; $display("FAIL addiu: got %h exp %h", {out_valid, branch_taken, dest_reg, data_out}, {1'b1, 1'b0, 5'd8, 32'd5});
    end
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL addiu_one_cycle: out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_alu();
    wb(5'd8, 32'd5);
    wb(5'd9, 32'd7);
    t_ins[0]  = enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h21);  t_dst[0]  = 5'd10; t_dat[0]  = 32'd12;
    t_ins[1]  = enc_r(5'd8, 5'd9, 5'd11, 5'd0, 6'h23);  t_dst[1]  = 5'd11; t_dat[1]  = 32'hFFFF_FFFE;
    t_ins[2]  = enc_r(5'd8, 5'd9, 5'd12, 5'd0, 6'h24);  t_dst[2]  = 5'd12; t_dat[2]  = 32'd5;
    t_ins[3]  = enc_r(5'd8, 5'd9, 5'd12, 5'd0, 6'h25);  t_dst[3]  = 5'd12; t_dat[3]  = 32'd7;
    t_ins[4]  = enc_r(5'd8, 5'd9, 5'd12, 5'd0, 6'h26);  t_dst[4]  = 5'd12; t_dat[4]  = 32'd2;
    t_ins[5]  = enc_r(5'd8, 5'd9, 5'd12, 5'd0, 6'h27);  t_dst[5]  = 5'd12; t_dat[5]  = 32'hFFFF_FFF8;
    t_ins[6]  = enc_r(5'd9, 5'd8, 5'd12, 5'd0, 6'h04);  t_dst[6]  = 5'd12; t_dat[6]  = 32'h280;
    t_ins[7]  = enc_r(5'd0, 5'd9, 5'd12, 5'd4, 6'h00);  t_dst[7]  = 5'd12; t_dat[7]  = 32'h70;
    t_ins[8]  = enc_i(6'h0d, 5'd0, 5'd12, 16'hFFFF);    t_dst[8]  = 5'd12; t_dat[8]  = 32'h0000_FFFF;
    t_ins[9]  = enc_i(6'h09, 5'd0, 5'd12, 16'hFFFF);    t_dst[9]  = 5'd12; t_dat[9]  = 32'hFFFF_FFFF;
    t_ins[10] = enc_i(6'h0f, 5'd0, 5'd12, 16'h8000);    t_dst[10] = 5'd12; t_dat[10] = 32'h8000_0000;
    t_ins[11] = enc_i(6'h0b, 5'd8, 5'd12, 16'hFFFF);    t_dst[11] = 5'd12; t_dat[11] = 32'd1;
    t_ins[12] = enc_i(6'h0e, 5'd9, 5'd12, 16'h000F);    t_dst[12] = 5'd12; t_dat[12] = 32'd8;
    t_ins[13] = enc_i(6'h23, 5'd9, 5'd13, 16'd8);       t_dst[13] = 5'd13; t_dat[13] = 32'd15;
    t_ins[14] = enc_r(5'd9, 5'd9, 5'd14, 5'd0, 6'h20);  t_dst[14] = 5'd14; t_dat[14] = 32'd14;
    for (int i = 0; i < 15; i++) begin
      exec(t_ins[i], 32'd0);
      tests_run++;
      if ({out_valid, dest_reg, data_out} !== {1'b1, t_dst[i], t_dat[i]}) begin
        tests_failed++;
        $display("FAIL alu[%0d]: got %h exp %h", i, {out_valid, dest_reg, data_out}, {1'b1, t_dst[i], t_dat[i]});
      end
    end
    exec(enc_i(6'h2b, 5'd8, 5'd9, 16'hFFFC), 32'd0);
    tests_run++;
    if ({out_valid, dest_reg, data_out, rt_data_out} !== {1'b1, 5'd0, 32'd1, 32'd7}) begin
      tests_failed++; $display("FAIL sw: got %h exp %h", {out_valid, dest_reg, data_out, rt_data_out}, {1'b1, 5'd0, 32'd1, 32'd7});
    end
    exec(32'd0, 32'd0);
    tests_run++;
    if ({out_valid, dest_reg, branch_taken} !== {1'b1, 5'd0, 1'b0}) begin
      tests_failed++; $display("FAIL nop: got %h exp %h", {out_valid, dest_reg, branch_taken}, {1'b1, 5'd0, 1'b0});
    end
    exec(enc_i(6'h3f, 5'd9, 5'd12, 16'd1), 32'd0);
    tests_run++;
    if ({out_valid, dest_reg, branch_taken} !== {1'b1, 5'd0, 1'b0}) begin
      tests_failed++; $display("FAIL unknown_op: got %h exp %h", {out_valid, dest_reg, branch_taken}, {1'b1, 5'd0, 1'b0});
    end
  endtask

  task automatic test_bypass();
    @(negedge clock);
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'd3;
    insn = enc_i(6'h09, 5'd8, 5'd12, 16'h0010); pc_in = 32'd0; valid_insn = 1'b1;
    @(negedge clock); wb_en = 1'b0; valid_insn = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({out_valid, dest_reg, data_out} !== {1'b1, 5'd12, 32'h13}) begin
      tests_failed++; $display("FAIL bypass: got %h exp %h", {out_valid, dest_reg, data_out}, {1'b1, 5'd12, 32'h13});
    end
    exec(enc_r(5'd8, 5'd0, 5'd13, 5'd0, 6'h21), 32'd0);
    tests_run++;
    if (data_out !== 32'd3) begin
      tests_failed++; $display("FAIL bypass_written: data_out got %h exp 3", data_out);
    end
    @(negedge clock);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    insn = enc_i(6'h09, 5'd0, 5'd14, 16'd1); valid_insn = 1'b1;
    @(negedge clock); wb_en = 1'b0; valid_insn = 1'b0;
    @(negedge clock);
    tests_run++;
    if (data_out !== 32'd1) begin
      tests_failed++; $display("FAIL r0_no_bypass: data_out got %h exp 1", data_out);
    end
    exec(enc_r(5'd0, 5'd0, 5'd15, 5'd0, 6'h21), 32'd0);
    tests_run++;
    if ({dest_reg, data_out} !== {5'd15, 32'd0}) begin
      tests_failed++; $display("FAIL r0_reads_zero: got %h exp %h", {dest_reg, data_out}, {5'd15, 32'd0});
    end
  endtask

  task automatic test_branch();
    exec(enc_i(6'h04, 5'd0, 5'd0, 16'd4), 32'h8002_0010);
    tests_run++;
    if ({branch_taken, branch_target, dest_reg} !== {1'b1, 32'h8002_0024, 5'd0}) begin
      tests_failed++; $display("FAIL beq: got %h exp %h", {branch_taken, branch_target, dest_reg}, {1'b1, 32'h8002_0024, 5'd0});
    end
    exec(enc_i(6'h05, 5'd0, 5'd0, 16'd4), 32'h8002_0010);
    tests_run++;
    if ({out_valid, branch_taken, dest_reg} !== {1'b1, 1'b0, 5'd0}) begin
      tests_failed++; $display("FAIL bne_not_taken: got %h exp %h", {out_valid, branch_taken, dest_reg}, {1'b1, 1'b0, 5'd0});
    end
    exec(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF), 32'h8002_0010);
    tests_run++;
    if ({branch_taken, branch_target} !== {1'b1, 32'h8002_0010}) begin
      tests_failed++; $display("FAIL beq_back: got %h exp %h", {branch_taken, branch_target}, {1'b1, 32'h8002_0010});
    end
    exec(enc_i(6'h07, 5'd9, 5'd0, 16'd2), 32'h0000_1000);
    tests_run++;
    if ({branch_taken, branch_target} !== {1'b1, 32'h0000_100C}) begin
      tests_failed++; $display("FAIL bgtz: got %h exp %h", {branch_taken, branch_target}, {1'b1, 32'h0000_100C});
    end
    exec(enc_i(6'h06, 5'd9, 5'd0, 16'd2), 32'h0000_1000);
    tests_run++;
    if (branch_taken !== 1'b0) begin
      tests_failed++; $display("FAIL blez_pos: branch_taken got %b exp 0", branch_taken);
    end
  endtask

  task automatic test_jump();
    exec(enc_j(6'h03, 26'h000_8000), 32'h8002_0000);
    tests_run++;
    if ({branch_taken, branch_target, dest_reg, data_out} !== {1'b1, 32'h8002_0000, 5'd31, 32'h8002_0008}) begin
      tests_failed++;
      $display("FAIL jal: got %h exp %h", {branch_taken, branch_target, dest_reg, data_out}, {1'b1, 32'h8002_0000, 5'd31, 32'h8002_0008});
    end
    exec(enc_j(6'h02, 26'h3FF_FFFF), 32'h1FFF_FFFC);
    tests_run++;
    if ({branch_taken, branch_target, dest_reg} !== {1'b1, 32'h2FFF_FFFC, 5'd0}) begin
      tests_failed++; $display("FAIL j_region: got %h exp %h", {branch_taken, branch_target, dest_reg}, {1'b1, 32'h2FFF_FFFC, 5'd0});
    end
    exec(enc_r(5'd9, 5'd0, 5'd5, 5'd0, 6'h09), 32'h0000_0100);
    tests_run++;
    if ({branch_taken, branch_target, dest_reg, data_out} !== {1'b1, 32'd7, 5'd5, 32'h108}) begin
      tests_failed++; $display("FAIL jalr: got %h exp %h", {branch_taken, branch_target, dest_reg, data_out}, {1'b1, 32'd7, 5'd5, 32'h108});
    end
    exec(enc_r(5'd9, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0000_0100);
    tests_run++;
    if ({branch_taken, branch_target, dest_reg} !== {1'b1, 32'd7, 5'd0}) begin
      tests_failed++; $display("FAIL jr: got %h exp %h", {branch_taken, branch_target, dest_reg}, {1'b1, 32'd7, 5'd0});
    end
  endtask

  task automatic test_signed();
    wb(5'd8, 32'hFFFF_FFFF);
    wb(5'd9, 32'd1);
    t_ins[0] = enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h2a);  t_dat[0] = 32'd1;
    t_ins[1] = enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h2b);  t_dat[1] = 32'd0;
    t_ins[2] = enc_r(5'd0, 5'd8, 5'd10, 5'd4, 6'h03);  t_dat[2] = 32'hFFFF_FFFF;
    t_ins[3] = enc_r(5'd0, 5'd8, 5'd10, 5'd28, 6'h02); t_dat[3] = 32'h0000_000F;
    t_ins[4] = enc_r(5'd9, 5'd8, 5'd10, 5'd0, 6'h06);  t_dat[4] = 32'h7FFF_FFFF;
    t_ins[5] = enc_i(6'h0a, 5'd8, 5'd10, 16'd0);       t_dat[5] = 32'd1;
    t_ins[6] = enc_r(5'd8, 5'd9, 5'd10, 5'd0, 6'h21);  t_dat[6] = 32'd0;
    t_ins[7] = enc_r(5'd9, 5'd8, 5'd10, 5'd0, 6'h22);  t_dat[7] = 32'd2;
    t_ins[8] = enc_i(6'h08, 5'd8, 5'd10, 16'h7FFF);    t_dat[8] = 32'h0000_7FFE;
    for (int i = 0; i < 9; i++) begin
      exec(t_ins[i], 32'd0);
      tests_run++;
      if ({out_valid, dest_reg, data_out} !== {1'b1, 5'd10, t_dat[i]}) begin
        tests_failed++;
        $display("FAIL signed[%0d]: got %h exp %h", i, {out_valid, dest_reg, data_out}, {1'b1, 5'd10, t_dat[i]});
      end
    end
    exec(enc_i(6'h01, 5'd8, 5'd0, 16'd2), 32'd0);
    tests_run++;
    if ({branch_taken, branch_target, dest_reg} !== {1'b1, 32'h0000_000C, 5'd0}) begin
      tests_failed++; $display("FAIL bltz: got %h exp %h", {branch_taken, branch_target, dest_reg}, {1'b1, 32'h0000_000C, 5'd0});
    end
    exec(enc_i(6'h01, 5'd8, 5'd1, 16'd2), 32'd0);
    tests_run++;
    if (branch_taken !== 1'b0) begin
      tests_failed++; $display("FAIL bgez_neg: branch_taken got %b exp 0", branch_taken);
    end
    exec(enc_i(6'h06, 5'd8, 5'd0, 16'd2), 32'd0);
    tests_run++;
    if (branch_taken !== 1'b1) begin
      tests_failed++; $display("FAIL blez_neg: branch_taken got %b exp 1", branch_taken);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock); insn = enc_i(6'h09, 5'd0, 5'd1, 16'd1); valid_insn = 1'b1;
    @(negedge clock); insn = enc_i(6'h09, 5'd0, 5'd2, 16'd2);
    @(negedge clock);
    tests_run++;
    if ({out_valid, dest_reg, data_out} !== {1'b1, 5'd1, 32'd1}) begin
      tests_failed++; $display("FAIL b2b_0: got %h exp %h", {out_valid, dest_reg, data_out}, {1'b1, 5'd1, 32'd1});
    end
    insn = enc_i(6'h09, 5'd0, 5'd3, 16'd3);
    @(negedge clock);
    tests_run++;
    if ({out_valid, dest_reg, data_out} !== {1'b1, 5'd2, 32'd2}) begin
      tests_failed++; $display("FAIL b2b_1: got %h exp %h", {out_valid, dest_reg, data_out}, {1'b1, 5'd2, 32'd2});
    end
    valid_insn = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({out_valid, dest_reg, data_out} !== {1'b1, 5'd3, 32'd3}) begin
      tests_failed++; $display("FAIL b2b_2: got %h exp %h", {out_valid, dest_reg, data_out}, {1'b1, 5'd3, 32'd3});
    end
    @(negedge clock);
    tests_run++;
    if ({out_valid, branch_taken} !== 2'b00) begin
      tests_failed++; $display("FAIL b2b_bubble: got %b exp 00", {out_valid, branch_taken});
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clock); insn = enc_i(6'h04, 5'd0, 5'd0, 16'd4); pc_in = 32'h8002_0010; valid_insn = 1'b1;
    @(negedge clock); insn = enc_i(6'h09, 5'd0, 5'd1, 16'd1); reset = 1'b1;
    @(negedge clock); reset = 1'b0; valid_insn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({out_valid, branch_taken} !== 2'b00) begin
        tests_failed++; $display("FAIL flush[%0d]: got %b exp 00", i, {out_valid, branch_taken});
      end
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addiu();
    test_alu();
    test_bypass();
    test_branch();
    test_jump();
    test_signed();
    test_back_to_back();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_execute_core.md
DECODE_EXECUTE_CORE -- requirements
Module: decode_execute_core

Interface
REQ-001 SHALL have parameter SP_RESET, default 32'h8002_0000, reset value of register r29.
REQ-002 SHALL have port clock, input, 1 bit; the only clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-004 SHALL have port insn, input, 32 bits; MIPS instruction word, opcode in the 6 most significant bits.
REQ-005 SHALL have port pc_in, input, 32 bits; address of insn.
REQ-006 SHALL have port valid_insn, input, 1 bit; insn/pc_in are valid this cycle.
REQ-007 SHALL have port wb_en, input, 1 bit; register write-back enable.
REQ-008 SHALL have port wb_addr, input, 5 bits; write-back register index.
REQ-009 SHALL have port wb_data, input, 32 bits; write-back data.
REQ-010 SHALL have port data_out, output, 32 bits; ALU result, effective address, or link value.
REQ-011 SHALL have port out_valid, output, 1 bit; data_out and the other result outputs are valid.
REQ-012 SHALL have port dest_reg, output, 5 bits; destination register index of the result (0 = none).
REQ-013 SHALL have port rt_data_out, output, 32 bits; rt operand, used as store data.
REQ-014 SHALL have port branch_taken, output, 1 bit; branch/jump redirect.
REQ-015 SHALL have port branch_target, output, 32 bits; redirect address.

Function
REQ-016 SHALL decode fields: opcode, rs, rt, rd, shamt, funct, imm16 and target26.
REQ-017 SHALL contain a 32x32-bit register file; r0 SHALL always read 0 and ignore writes.
REQ-018 SHALL write wb_data to wb_addr on a rising edge when wb_en=1 and wb_addr!=0.
REQ-019 SHALL bypass a same-cycle write to a read of the same nonzero index, so the read returns wb_data.
REQ-020 SHALL use two stages. Stage 1 registers the decoded fields and the rs/rt read data on the edge where valid_insn=1. Stage 2 registers the results on the next edge.
REQ-021 Total latency SHALL be 2 cycles: insn sampled at edge N gives out_valid=1 after edge N+1 (held for exactly one cycle per instruction); back-to-back instructions SHALL be accepted every cycle.
REQ-022 R-type funct codes to support: ADD/ADDU, SUB/SUBU, AND, OR, XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA (by shamt), SLLV/SRLV/SRAV (by rs[4:0]), JR, JALR. dest_reg = rd.
REQ-023 I-type opcodes to support, with dest_reg = rt:
- ADDI/ADDIU and SLTI/SLTIU: sign-extended imm16.
- ANDI/ORI/XORI: zero-extended imm16.
- LUI: imm16<<16.
REQ-024 LW/SW/LB/LBU/SB: data_out = rs + sign-extended imm16. Loads: dest_reg = rt. Stores: dest_reg = 0, rt_data_out = rt value.
REQ-025 All arithmetic SHALL be 32-bit modulo with no overflow trap.
REQ-026 BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ:
- branch_target = pc_in + 4 + (sign-extended imm16 << 2).
- branch_taken per signed comparison.
- dest_reg = 0.
REQ-027 J/JAL: branch_taken = 1, branch_target = {(pc_in+4)[31:28], target26, 2'b00}.
REQ-028 JAL and JALR: data_out = pc_in + 8. JAL: dest_reg = 31. JALR: dest_reg = rd.
REQ-029 JR/JALR: branch_target = rs value, branch_taken = 1.
REQ-030 Unknown opcode/funct and NOP (all-zero word) SHALL produce out_valid=1, dest_reg=0, branch_taken=0.
REQ-031 When valid_insn=0, stage 1 SHALL capture a bubble, giving out_valid=0 two cycles later.
REQ-032 branch_taken SHALL be 0 whenever out_valid=0.

Reset
REQ-033 On a rising edge with reset=1:
- registers r1..r31 SHALL clear to 0, except r29 = SP_RESET.
- both stage valid bits SHALL clear.
- data_out, rt_data_out, branch_target, dest_reg, out_valid and branch_taken SHALL be 0 from the next cycle.
REQ-034 Reset SHALL override a simultaneous wb_en write and a simultaneous valid_insn.
REQ-035 Reset asserted mid-pipeline SHALL discard all in-flight instructions; no out_valid SHALL appear for them.

Verification
REQ-036 Reset, then ADDIU r8,r0,5 -> 2 cycles later: out_valid=1, data_out=5, dest_reg=8.
REQ-037 Write back r8=5 and r9=7, then ADDU r10,r8,r9 -> data_out=12, dest_reg=10. Then SUBU r11,r8,r9 -> data_out=32'hFFFF_FFFE.
REQ-038 wb_en writes r8=3 in the same cycle an instruction reading r8 is issued -> operand 3 is used (bypass). A write to r0 -> r0 still reads 0.
REQ-039 pc_in=32'h8002_0010 with BEQ r0,r0,offset 4 -> branch_taken=1, branch_target=32'h8002_0024. BNE r0,r0 -> branch_taken=0.
REQ-040 JAL at pc_in=32'h8002_0000 with target26=26'h0008000 -> branch_target=32'h8002_0000, data_out=32'h8002_0008, dest_reg=31.
REQ-041 SLT with r8=32'hFFFF_FFFF, r9=1 -> data_out=1; SLTU with the same operands -> data_out=0. Assert reset with two instructions in flight -> no out_valid follows.
